// File: rtl/arbmux_pkg.sv
// Shared defaults and helpers for the round-robin arbitrating stream mux.
// Optional packet locking is enabled by defining ARBMUX_LOCK_EN.
package arbmux_pkg;

    localparam int unsigned ARBMUX_WIDTH    = 16;
    localparam int unsigned ARBMUX_CHANNELS = 4;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scans requests starting after ptr.
// With lock asserted only the channel at ptr may be granted (ARBMUX_LOCK_EN builds).
module rr_arbiter #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SELW     = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SELW-1:0]     ptr,
    input  logic                lock,
    output logic [CHANNELS-1:0] grant_c,
    output logic [SELW-1:0]     idx_c,
    output logic                any_c
);

    logic [31:0]         cand;
    logic [CHANNELS-1:0] onehot;

    // Shift-based selects keep every index width-clean for any CHANNELS.
    always_comb begin
        grant_c = '0;
        idx_c   = '0;
        any_c   = 1'b0;
        cand    = '0;
        onehot  = '0;
        if (lock) begin
            cand   = 32'(ptr);
            onehot = CHANNELS'(1) << cand;
            if (|(req & onehot)) begin
                grant_c = onehot;
                idx_c   = ptr;
                any_c   = 1'b1;
            end
        end else begin
            for (int unsigned k = 1; k <= CHANNELS; k++) begin
                cand   = (32'(ptr) + 32'(k)) % 32'(CHANNELS);
                onehot = CHANNELS'(1) << cand;
                if (!any_c && |(req & onehot)) begin
                    grant_c = onehot;
                    idx_c   = SELW'(cand);
                    any_c   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// N-way round-robin arbitrating stream mux with a single registered output beat.
// Define ARBMUX_LOCK_EN to add in_last/out_last and hold the grant for a whole packet.
module arb_mux_n
    import arbmux_pkg::*;
#(
    parameter int unsigned WIDTH    = ARBMUX_WIDTH,
    parameter int unsigned CHANNELS = ARBMUX_CHANNELS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
`ifdef ARBMUX_LOCK_EN
    input  logic [CHANNELS-1:0]       in_last,
    output logic                      out_last,
`endif
    output logic [WIDTH-1:0]          out_data,
    output logic [clog2_min1(CHANNELS)-1:0] out_sel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int unsigned SELW = clog2_min1(CHANNELS);

    logic [SELW-1:0]     ptr_q;
    logic                lock_c;
    logic [CHANNELS-1:0] grant_c;
    logic [SELW-1:0]     idx_c;
    logic                any_c;
    logic                free_c;
    logic                xfer_c;
    logic [WIDTH-1:0]    sel_data_c;

`ifdef ARBMUX_LOCK_EN
    logic locked_q;
    assign lock_c = locked_q;
`else
    assign lock_c = 1'b0;
`endif

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SELW     (SELW)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .lock    (lock_c),
        .grant_c (grant_c),
        .idx_c   (idx_c),
        .any_c   (any_c)
    );

    // Nothing is accepted while reset is held.
    assign free_c     = (!out_valid || out_ready) && !rst;
    assign in_ready   = grant_c & {CHANNELS{free_c}};
    assign xfer_c     = any_c && free_c;
    assign sel_data_c = WIDTH'(in_data >> (32'(idx_c) * 32'(WIDTH)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr_q     <= SELW'(CHANNELS - 1);
        end else if (xfer_c) begin
            out_valid <= 1'b1;
            out_data  <= sel_data_c;
            out_sel   <= idx_c;
            ptr_q     <= idx_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ARBMUX_LOCK_EN
    // Stay on the granted channel until its last beat has been taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked_q <= 1'b0;
            out_last <= 1'b0;
        end else if (xfer_c) begin
            locked_q <= !(|(in_last & grant_c));
            out_last <= |(in_last & grant_c);
        end
    end
`endif

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n against a behavioural round-robin model.
// Lock behaviour is exercised when ARBMUX_LOCK_EN is defined.
module tb_arb_mux_n;
    import arbmux_pkg::*;

    localparam int unsigned W  = ARBMUX_WIDTH;
    localparam int unsigned CH = ARBMUX_CHANNELS;
    localparam int unsigned SW = clog2_min1(CH);

    logic            clk = 1'b0;
    logic            rst;
    logic [CH*W-1:0] in_data;
    logic [W-1:0]    dat [CH];
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_sel;
    logic            out_valid;
    logic            out_ready;
`ifdef ARBMUX_LOCK_EN
    logic [CH-1:0]   in_last;
    logic            out_last;
    bit              m_locked;
    bit              m_last;
`endif

    int       n_cmp = 0;
    int       n_bad = 0;
    int       m_ptr;
    bit       m_valid;
    logic [W-1:0] m_data;
    int       m_sel;

    for (genvar c = 0; c < CH; c++) begin : g_pack
        assign in_data[c*W +: W] = dat[c];
    end

    always #5 clk = ~clk;

    arb_mux_n #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef ARBMUX_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Channel the rules say should be granted right now, or -1.
    function automatic int exp_grant();
        int c;
        if (rst) return -1;
        if (m_valid && !out_ready) return -1;
`ifdef ARBMUX_LOCK_EN
        if (m_locked) return in_valid[m_ptr] ? m_ptr : -1;
`endif
        for (int k = 1; k <= int'(CH); k++) begin
            c = (m_ptr + k) % int'(CH);
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    task automatic cycle();
        int g;
        #1;
        g = exp_grant();
        chk("in_ready", 32'(in_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1'b1;
            m_data  = dat[g];
            m_sel   = g;
            m_ptr   = g;
`ifdef ARBMUX_LOCK_EN
            m_locked = !in_last[g];
            m_last   = in_last[g];
`endif
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_sel", 32'(out_sel), 32'(m_sel));
`ifdef ARBMUX_LOCK_EN
        chk("out_last", 32'(out_last), 32'(m_last));
`endif
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
        m_ptr   = int'(CH) - 1;
`ifdef ARBMUX_LOCK_EN
        m_locked = 1'b0;
        m_last   = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) cycle();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = '1;
        out_ready = 1'b0;
`ifdef ARBMUX_LOCK_EN
        in_last   = '1;
`endif
        for (int c = 0; c < int'(CH); c++) dat[c] = W'(c * 32'h1111);

        // Reset with every channel requesting.
        do_reset();
        #1;
        chk("rst_release_ready", 32'(in_ready), 32'd1);

        // Fairness: all valid, consumer always ready.
        out_ready = 1'b1;
        cycle();
        chk("first_sel", 32'(out_sel), 32'd0);
        for (int k = 1; k <= int'(CH); k++) begin
            cycle();
            chk("rr_data", 32'(out_data), 32'(W'((k % int'(CH)) * 32'h1111)));
        end

        // Backpressure on a single channel.
        in_valid = CH'(4);
        cycle();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("held_data", 32'(out_data), 32'(W'(32'h2222)));
            chk("held_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("resume_ready", 32'(in_ready), 32'd4);
        cycle();

        // Wrap-around from channel CH-1 back to 0.
        in_valid = CH'(1) << (CH - 1);
        cycle();
        in_valid = (CH'(1) << (CH - 1)) | CH'(1);
        cycle();
        chk("wrap_sel", 32'(out_sel), 32'd0);

        // Asynchronous reset while a beat is stalled.
        in_valid = CH'(4);
        cycle();
        out_ready = 1'b0;
        in_valid  = '0;
        cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_data", 32'(out_data), 32'd0);
        do_reset();
        in_valid  = '1;
        out_ready = 1'b1;
        cycle();
        chk("post_rst_sel", 32'(out_sel), 32'd0);

`ifdef ARBMUX_LOCK_EN
        // Packet lock: channel 1 keeps the grant until its last beat.
        do_reset();
        out_ready = 1'b1;
        in_valid  = CH'(1);
        in_last   = '1;
        cycle();
        in_valid  = CH'(3);
        in_last   = CH'(1);
        cycle();
        chk("lock_sel0", 32'(out_sel), 32'd1);
        cycle();
        chk("lock_sel1", 32'(out_sel), 32'd1);
        in_last = CH'(3);
        cycle();
        chk("lock_sel2", 32'(out_sel), 32'd1);
        chk("lock_last", 32'(out_last), 32'd1);
        cycle();
        chk("unlock_sel", 32'(out_sel), 32'd0);
`endif

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            in_valid  = CH'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < int'(CH); c++) dat[c] = W'($urandom);
`ifdef ARBMUX_LOCK_EN
            in_last = CH'($urandom);
`endif
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
